// File: rtl/cc_bcd_updown_counter_pkg.sv
// Shared constants for the BCD up/down counter.
// Holds the digit encoding limits, the command codes used between the
// priority decoder and the digit cells, and the load clamp helper.
package cc_bcd_updown_counter_pkg;

  localparam int BCD_DIGIT_W = 4;

  localparam logic [BCD_DIGIT_W-1:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [BCD_DIGIT_W-1:0] BCD_DIGIT_MIN = 4'd0;

  // One command per clock edge, already resolved for priority and saturation.
  typedef logic [2:0] cmd_t;

  localparam cmd_t CMD_HOLD  = 3'd0;
  localparam cmd_t CMD_UP    = 3'd1;
  localparam cmd_t CMD_DOWN  = 3'd2;
  localparam cmd_t CMD_LOAD  = 3'd3;
  localparam cmd_t CMD_CLEAR = 3'd4;

  // A loaded nibble above 9 is not BCD; pin it to 9 so the register stays valid.
  function automatic logic [BCD_DIGIT_W-1:0] clampDigit(input logic [BCD_DIGIT_W-1:0] raw);
    return (raw > BCD_DIGIT_MAX) ? BCD_DIGIT_MAX : raw;
  endfunction

endpackage

// File: rtl/cc_bcd_updown_counter_digit_cell.sv
// One decade of the BCD counter.
// Computes the next value of a single digit from the resolved command and the
// ripple carry/borrow arriving from the less significant digit. Carry and
// borrow are propagated only through digits sitting at 9 or 0 respectively,
// so the chain settles combinationally within one cycle.
module cc_bcd_digit_cell
  import cc_bcd_updown_counter_pkg::*;
(
  input  cmd_t                   cmd,
  input  logic [BCD_DIGIT_W-1:0] digitQ,
  input  logic                   carryIn,
  input  logic                   borrowIn,
  input  logic [BCD_DIGIT_W-1:0] loadDigit,
  output logic [BCD_DIGIT_W-1:0] nextDigit,
  output logic                   carryOut,
  output logic                   borrowOut,
  output logic                   is9,
  output logic                   is0
);

  assign is9       = (digitQ == BCD_DIGIT_MAX);
  assign is0       = (digitQ == BCD_DIGIT_MIN);
  assign carryOut  = carryIn & is9;
  assign borrowOut = borrowIn & is0;

  // Next digit value: clear, clamped load, increment with wrap, decrement with wrap, or hold.
  always_comb begin
    nextDigit = digitQ;
    case (cmd)
      CMD_CLEAR: nextDigit = BCD_DIGIT_MIN;
      CMD_LOAD:  nextDigit = clampDigit(loadDigit);
      CMD_UP: begin
        if (carryIn) begin
          nextDigit = is9 ? BCD_DIGIT_MIN : (digitQ + 4'd1);
        end
      end
      CMD_DOWN: begin
        if (borrowIn) begin
          nextDigit = is0 ? BCD_DIGIT_MAX : (digitQ - 4'd1);
        end
      end
      default:   nextDigit = digitQ;
    endcase
  end

endmodule

// File: rtl/cc_bcd_updown_counter.sv
// Multi-digit BCD up/down counter used for the score (up) and round timer (down).
// A priority decoder resolves clear > load > single step > hold into one
// command, steps that would run past all-9 or all-0 are turned into holds,
// and a row of decade cells computes the next packed BCD value. Terminal
// flags are decoded from the count register; the expiry pulse is registered
// alongside the count so it lines up with the first all-zero cycle.
module cc_bcd_updown_counter
  import cc_bcd_updown_counter_pkg::*;
#(
  parameter  int COUNTER_DIGITS    = 4,
  localparam int COUNTER_DATAWIDTH = BCD_DIGIT_W * COUNTER_DIGITS
) (
  input  logic                         CC_BCDCOUNTER_CLOCK_50,
  input  logic                         CC_BCDCOUNTER_RESET_InLow,
  input  logic                         CC_BCDCOUNTER_clear_InHigh,
  input  logic                         CC_BCDCOUNTER_load_InHigh,
  input  logic [COUNTER_DATAWIDTH-1:0] CC_BCDCOUNTER_data_InBUS,
  input  logic                         CC_BCDCOUNTER_up_InHigh,
  input  logic                         CC_BCDCOUNTER_down_InHigh,
  output logic [COUNTER_DATAWIDTH-1:0] CC_BCDCOUNTER_data_OutBUS,
  output logic                         CC_BCDCOUNTER_zero_OutLow,
  output logic                         CC_BCDCOUNTER_max_OutLow,
  output logic                         CC_BCDCOUNTER_expired_OutHigh
);

  logic [COUNTER_DATAWIDTH-1:0] countQ;
  logic [COUNTER_DATAWIDTH-1:0] countNext;
  logic                         expiredQ;
  cmd_t                         cmd;

  logic [COUNTER_DIGITS:0]      carryChain;
  logic [COUNTER_DIGITS:0]      borrowChain;
  logic [COUNTER_DIGITS-1:0]    is9Vec;
  logic [COUNTER_DIGITS-1:0]    is0Vec;
  logic                         allNine;
  logic                         allZero;
  logic                         unusedChainEnd;

  // Digit 0 always receives the step; higher digits only see it through the ripple.
  assign carryChain[0]  = 1'b1;
  assign borrowChain[0] = 1'b1;

  // The ripple out of the top digit duplicates allNine/allZero and is not needed.
  assign unusedChainEnd = carryChain[COUNTER_DIGITS] ^ borrowChain[COUNTER_DIGITS];

  assign allNine = &is9Vec;
  assign allZero = &is0Vec;

  // Resolve strobe priority and block any step that would run past the terminal values.
  always_comb begin
    cmd = CMD_HOLD;
    if (CC_BCDCOUNTER_clear_InHigh) begin
      cmd = CMD_CLEAR;
    end else if (CC_BCDCOUNTER_load_InHigh) begin
      cmd = CMD_LOAD;
    end else if (CC_BCDCOUNTER_up_InHigh && !CC_BCDCOUNTER_down_InHigh) begin
      cmd = allNine ? CMD_HOLD : CMD_UP;
    end else if (CC_BCDCOUNTER_down_InHigh && !CC_BCDCOUNTER_up_InHigh) begin
      cmd = allZero ? CMD_HOLD : CMD_DOWN;
    end
  end

  for (genvar d = 0; d < COUNTER_DIGITS; d++) begin : gDigit
    cc_bcd_digit_cell uCell (
      .cmd       (cmd),
      .digitQ    (countQ[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .carryIn   (carryChain[d]),
      .borrowIn  (borrowChain[d]),
      .loadDigit (CC_BCDCOUNTER_data_InBUS[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .nextDigit (countNext[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .carryOut  (carryChain[d+1]),
      .borrowOut (borrowChain[d+1]),
      .is9       (is9Vec[d]),
      .is0       (is0Vec[d])
    );
  end

  // Count register and expiry pulse; a down step can only land on zero from value 1
  // because stepping down from zero is already blocked above.
  always_ff @(posedge CC_BCDCOUNTER_CLOCK_50 or negedge CC_BCDCOUNTER_RESET_InLow) begin
    if (!CC_BCDCOUNTER_RESET_InLow) begin
      countQ   <= '0;
      expiredQ <= 1'b0;
    end else begin
      countQ   <= countNext;
      expiredQ <= (cmd == CMD_DOWN) && (countNext == '0);
    end
  end

  assign CC_BCDCOUNTER_data_OutBUS     = countQ;
  assign CC_BCDCOUNTER_zero_OutLow     = ~allZero;
  assign CC_BCDCOUNTER_max_OutLow      = ~allNine;
  assign CC_BCDCOUNTER_expired_OutHigh = expiredQ;

endmodule

// File: tb/tb_cc_bcd_updown_counter.sv
// Directed bench for the 4-digit BCD up/down counter.
module tb_cc_bcd_updown_counter;

  logic        clk;
  logic        rstN;
  logic        clearIn;
  logic        loadIn;
  logic [15:0] dataIn;
  logic        upIn;
  logic        downIn;
  logic [15:0] dataOut;
  logic        zeroOutLow;
  logic        maxOutLow;
  logic        expiredOut;

  int checks;
  int errors;

  cc_bcd_updown_counter #(.COUNTER_DIGITS(4)) dut (
    .CC_BCDCOUNTER_CLOCK_50        (clk),
    .CC_BCDCOUNTER_RESET_InLow     (rstN),
    .CC_BCDCOUNTER_clear_InHigh    (clearIn),
    .CC_BCDCOUNTER_load_InHigh     (loadIn),
    .CC_BCDCOUNTER_data_InBUS      (dataIn),
    .CC_BCDCOUNTER_up_InHigh       (upIn),
    .CC_BCDCOUNTER_down_InHigh     (downIn),
    .CC_BCDCOUNTER_data_OutBUS     (dataOut),
    .CC_BCDCOUNTER_zero_OutLow     (zeroOutLow),
    .CC_BCDCOUNTER_max_OutLow      (maxOutLow),
    .CC_BCDCOUNTER_expired_OutHigh (expiredOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal to packed 4-digit BCD, used as the reference for the countdown.
  function automatic logic [15:0] toBcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  task automatic idleInputs();
    clearIn = 1'b0;
    loadIn  = 1'b0;
    upIn    = 1'b0;
    downIn  = 1'b0;
    dataIn  = 16'h0000;
  endtask

  // Load a value in one cycle; returns at the negedge after the loading edge.
  task automatic doLoad(input logic [15:0] v);
    idleInputs();
    loadIn = 1'b1;
    dataIn = v;
    @(negedge clk);
    loadIn = 1'b0;
  endtask

  task automatic test_reset();
    idleInputs();
    rstN = 1'b0;
    @(negedge clk);
    checks++;
    if (dataOut !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", dataOut); end
    checks++;
    if (zeroOutLow !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", zeroOutLow); end
    checks++;
    if (maxOutLow !== 1'b1) begin errors++; $display("FAIL reset_max: got %b expected 1", maxOutLow); end
    checks++;
    if (expiredOut !== 1'b0) begin errors++; $display("FAIL reset_expired: got %b expected 0", expiredOut); end
    rstN = 1'b1;
    @(negedge clk);
    // Mid-operation reset between edges
    doLoad(16'h0457);
    checks++;
    if (dataOut !== 16'h0457) begin errors++; $display("FAIL midreset_preload: got %h expected 0457", dataOut); end
    #2;
    rstN = 1'b0;
    #1;
    checks++;
    if (dataOut !== 16'h0000) begin errors++; $display("FAIL midreset_data: got %h expected 0000", dataOut); end
    checks++;
    if (zeroOutLow !== 1'b0 || maxOutLow !== 1'b1 || expiredOut !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flags: got zero=%b max=%b exp=%b expected 0 1 0", zeroOutLow, maxOutLow, expiredOut);
    end
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_carry();
    doLoad(16'h0099);
    upIn = 1'b1;
    @(negedge clk);
    upIn = 1'b0;
    checks++;
    if (dataOut !== 16'h0100) begin errors++; $display("FAIL carry_0099: got %h expected 0100", dataOut); end
    checks++;
    if (zeroOutLow !== 1'b1 || maxOutLow !== 1'b1 || expiredOut !== 1'b0) begin
      errors++;
      $display("FAIL carry_0099_flags: got zero=%b max=%b exp=%b expected 1 1 0", zeroOutLow, maxOutLow, expiredOut);
    end
    doLoad(16'h0999);
    upIn = 1'b1;
    @(negedge clk);
    upIn = 1'b0;
    checks++;
    if (dataOut !== 16'h1000) begin errors++; $display("FAIL carry_0999: got %h expected 1000", dataOut); end
    checks++;
    if (zeroOutLow !== 1'b1 || maxOutLow !== 1'b1 || expiredOut !== 1'b0) begin
      errors++;
      $display("FAIL carry_0999_flags: got zero=%b max=%b exp=%b expected 1 1 0", zeroOutLow, maxOutLow, expiredOut);
    end
  endtask

  task automatic test_saturate_up();
    doLoad(16'h9998);
    checks++;
    if (maxOutLow !== 1'b1) begin errors++; $display("FAIL satup_premax: got %b expected 1", maxOutLow); end
    upIn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (dataOut !== 16'h9999) begin errors++; $display("FAIL satup_data[%0d]: got %h expected 9999", i, dataOut); end
      checks++;
      if (maxOutLow !== 1'b0 || zeroOutLow !== 1'b1 || expiredOut !== 1'b0) begin
        errors++;
        $display("FAIL satup_flags[%0d]: got max=%b zero=%b exp=%b expected 0 1 0", i, maxOutLow, zeroOutLow, expiredOut);
      end
    end
    upIn = 1'b0;
  endtask

  task automatic test_borrow_expiry();
    logic [15:0] expData;
    logic        expExp;
    logic        expZero;
    doLoad(16'h0100);
    downIn = 1'b1;
    for (int i = 1; i <= 101; i++) begin
      @(negedge clk);
      expData = toBcd((100 - i) > 0 ? (100 - i) : 0);
      expExp  = (i == 100);
      expZero = (i >= 100) ? 1'b0 : 1'b1;
      checks++;
      if (dataOut !== expData) begin errors++; $display("FAIL borrow_data[%0d]: got %h expected %h", i, dataOut, expData); end
      checks++;
      if (expiredOut !== expExp) begin errors++; $display("FAIL borrow_expired[%0d]: got %b expected %b", i, expiredOut, expExp); end
      checks++;
      if (zeroOutLow !== expZero) begin errors++; $display("FAIL borrow_zero[%0d]: got %b expected %b", i, zeroOutLow, expZero); end
    end
    downIn = 1'b0;
  endtask

  task automatic test_load_clamp_priority();
    doLoad(16'h0321);
    idleInputs();
    loadIn = 1'b1;
    upIn   = 1'b1;
    dataIn = 16'h12F4;
    @(negedge clk);
    checks++;
    if (dataOut !== 16'h1294) begin errors++; $display("FAIL load_clamp: got %h expected 1294", dataOut); end
    upIn    = 1'b0;
    clearIn = 1'b1;
    loadIn  = 1'b1;
    dataIn  = 16'h5555;
    @(negedge clk);
    idleInputs();
    checks++;
    if (dataOut !== 16'h0000) begin errors++; $display("FAIL clear_over_load: got %h expected 0000", dataOut); end
    checks++;
    if (expiredOut !== 1'b0 || zeroOutLow !== 1'b0) begin
      errors++;
      $display("FAIL clear_flags: got exp=%b zero=%b expected 0 0", expiredOut, zeroOutLow);
    end
    // Load of a value with every nibble above 9 clamps to the max
    doLoad(16'hABCF);
    checks++;
    if (dataOut !== 16'h9999 || maxOutLow !== 1'b0) begin
      errors++;
      $display("FAIL load_clamp_all: got %h max=%b expected 9999 0", dataOut, maxOutLow);
    end
    // Load of zero from a nonzero value does not raise expiry
    doLoad(16'h0000);
    checks++;
    if (dataOut !== 16'h0000 || expiredOut !== 1'b0) begin
      errors++;
      $display("FAIL load_zero: got %h exp=%b expected 0000 0", dataOut, expiredOut);
    end
  endtask

  task automatic test_simultaneous();
    doLoad(16'h0500);
    upIn   = 1'b1;
    downIn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (dataOut !== 16'h0500) begin errors++; $display("FAIL simul_data[%0d]: got %h expected 0500", i, dataOut); end
      checks++;
      if (zeroOutLow !== 1'b1 || maxOutLow !== 1'b1 || expiredOut !== 1'b0) begin
        errors++;
        $display("FAIL simul_flags[%0d]: got zero=%b max=%b exp=%b expected 1 1 0", i, zeroOutLow, maxOutLow, expiredOut);
      end
    end
    idleInputs();
  endtask

  task automatic test_back_to_back();
    doLoad(16'h0002);
    downIn = 1'b1;
    @(negedge clk);
    checks++;
    if (dataOut !== 16'h0001 || expiredOut !== 1'b0) begin
      errors++;
      $display("FAIL b2b_step1: got %h exp=%b expected 0001 0", dataOut, expiredOut);
    end
    downIn = 1'b0;
    upIn   = 1'b1;
    @(negedge clk);
    checks++;
    if (dataOut !== 16'h0002) begin errors++; $display("FAIL b2b_up: got %h expected 0002", dataOut); end
    upIn = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstN   = 1'b0;
    idleInputs();
    test_reset();
    test_carry();
    test_saturate_up();
    test_borrow_expiry();
    test_load_clamp_priority();
    test_simultaneous();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
